axi_read_arbiter: RTL
=====================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL take parameter NUM_M, default 2: number of requesting masters.
REQ-003 The block SHALL take parameter MIDX_BITS, default 2: master index width, with 2^MIDX_BITS >= NUM_M.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ARID_M/ARADDR_M/ARLEN_M/ARSIZE_M/ARBURST_M  in  [NUM_M] x AXI widths  per-master read-address payload.
REQ-007 ARVALID_M  in  NUM_M  per-master AR request; ARREADY_M  out  NUM_M  per-master AR accept.
REQ-008 RID_M/RDATA_M/RRESP_M/RLAST_M/RVALID_M  out  [NUM_M] x AXI widths  per-master read data; RREADY_M  in  NUM_M.
REQ-009 ARID_S (AXI_IDS_BITS)/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S/ARVALID_S  out  single slave AR channel; ARREADY_S  in  1.
REQ-010 RID_S/RDATA_S/RRESP_S/RLAST_S/RVALID_S  in  single slave R channel; RREADY_S  out  1.
REQ-011 grant_idx  out  MIDX_BITS  current owner; busy  out  1  high outside IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ADDR and DATA.
REQ-013 IDLE: if any ARVALID_M is set, the block SHALL register the winner into grant_idx, latch its AR payload, and go to ADDR next cycle.
REQ-014 IDLE: the block SHALL drive ARREADY_M=0 for all masters (winner is accepted in ADDR).
REQ-015 ADDR: ARVALID_S SHALL be 1 and the payload SHALL come from the granted master; ARREADY_M[grant_idx] SHALL equal ARREADY_S and all other bits SHALL be 0.
REQ-016 ADDR: on ARVALID_S & ARREADY_S the block SHALL go to DATA.
REQ-017 ARID_S SHALL equal {grant_idx zero-extended to AXI_IDS_BITS-AXI_ID_BITS, ARID_M[grant_idx]}.
REQ-018 DATA: RVALID_M[grant_idx] SHALL equal RVALID_S, RREADY_S SHALL equal RREADY_M[grant_idx], RID_M SHALL equal RID_S[AXI_ID_BITS-1:0], and RDATA/RRESP/RLAST SHALL pass through unregistered.
REQ-019 DATA: non-granted masters SHALL see RVALID_M=0.
REQ-020 DATA: on RVALID_S & RREADY_S & RLAST_S the block SHALL go to IDLE, giving a minimum 1-cycle gap before the next grant.
REQ-021 Outside DATA, RREADY_S SHALL be 0 and every RVALID_M SHALL be 0.
REQ-022 The grant SHALL be held across all ARLEN+1 beats; no other master is granted until RLAST completes.
REQ-023 Burst beats are not counted; completion SHALL be determined by RLAST_S alone.
REQ-024 A request withdrawn after it wins (an AXI violation) SHALL be ignored: the latched payload is still issued.
REQ-025 Simultaneous requests SHALL be resolved per the Configuration section.
REQ-026 A request arriving in ADDR or DATA SHALL wait and SHALL NOT be dropped.

Reset
REQ-027 On rst: state=IDLE, grant_idx=0, RR pointer=0, ARVALID_S=0, RREADY_S=0, ARREADY_M=0, RVALID_M=0, busy=0.
REQ-028 All latched payload registers SHALL reset to 0.
REQ-029 Reset mid-burst SHALL abandon the transaction with no completion beat; the slave is reset together with the block.

Configuration
REQ-030 With macro ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer; pointer = winner+1 mod NUM_M on entry to ADDR.
REQ-031 With ARB_RR_EN undefined, arbitration SHALL be fixed priority, lowest index wins, and no pointer register is built.

Structure
REQ-032 AXI width macros SHALL come from the shared AXI define header.
REQ-033 The FSM state enum and a MIDX_BITS-based index type SHALL live in package axi_arb_pkg.
REQ-034 The winner-select logic SHALL be one sub-module, arb_pick, containing the RR/fixed variants; everything else is flat.

Verification
REQ-035 Single request: M0 ARADDR=0x0000_1000, ARLEN=3, ARID=4'h2 -> ARID_S=8'h02, ARVALID_S rises 1 cycle after ARVALID_M0, 4 beats reach M0 only, busy falls after RLAST.
REQ-036 Simultaneous M0/M1 with RR, pointer=0 -> order M0, M1, M0; without ARB_RR_EN -> M0 always wins while it requests.
REQ-037 M1 requests during M0's 8-beat burst -> M1 ARVALID_S rises exactly 2 cycles after M0's RLAST handshake; ARID_S=8'h1x.
REQ-038 Slave stalls: ARREADY_S held 0 for 5 cycles, then RREADY_M0 toggled 0/1 per beat -> no lost or duplicated beat, and payload is stable while stalled.
REQ-039 rst asserted at beat 2 of a 4-beat burst -> next cycle all outputs match REQ-027, and a fresh M1 request is granted normally.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI read arbiter: FSM state encoding and the master index type.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } arb_state_e;

  localparam int ARB_MIDX_BITS = 2;
  typedef logic [ARB_MIDX_BITS-1:0] midx_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select over the per-master request vector.
// ARB_RR_EN: round-robin search starting at ptr; otherwise fixed priority, lowest index wins.
module arb_pick #(
  parameter int NUM_M     = 2,
  parameter int MIDX_BITS = 2
) (
`ifdef ARB_RR_EN
  input  logic [MIDX_BITS-1:0] ptr,
`endif
  input  logic [NUM_M-1:0]     req,
  output logic                 any,
  output logic [MIDX_BITS-1:0] winner
);

`ifdef ARB_RR_EN
  int cand;

  // Walk from the farthest candidate back to ptr so the first hit after ptr is written last.
  always_comb begin
    any    = |req;
    winner = '0;
    cand   = 0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_M) cand = cand - NUM_M;
      for (int j = 0; j < NUM_M; j++) begin
        if (j == cand && req[j]) winner = MIDX_BITS'(j);
      end
    end
  end
`else
  always_comb begin
    any    = |req;
    winner = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (req[i]) winner = MIDX_BITS'(i);
    end
  end
`endif

endmodule

// File: rtl/axi_define.svh
// Shared AXI field widths for the read-path blocks.
// ARID_S is wider than ARID_M so the owning master's index can be prepended to the ID.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH

`define AXI_ID_BITS    4
`define AXI_IDS_BITS   8
`define AXI_ADDR_BITS  32
`define AXI_DATA_BITS  32
`define AXI_LEN_BITS   8
`define AXI_SIZE_BITS  3
`define AXI_BURST_BITS 2
`define AXI_RESP_BITS  2

`endif

// File: rtl/axi_read_arbiter.sv
// N-master to 1-slave AXI read arbiter, one transaction in flight; grant held until RLAST.
// Optional macro ARB_RR_EN selects round-robin arbitration (default: fixed priority).
`include "axi_define.svh"

module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int MIDX_BITS = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_M*`AXI_ID_BITS-1:0]         ARID_M,
  input  logic [NUM_M*`AXI_ADDR_BITS-1:0]       ARADDR_M,
  input  logic [NUM_M*`AXI_LEN_BITS-1:0]        ARLEN_M,
  input  logic [NUM_M*`AXI_SIZE_BITS-1:0]       ARSIZE_M,
  input  logic [NUM_M*`AXI_BURST_BITS-1:0]      ARBURST_M,
  input  logic [NUM_M-1:0]                      ARVALID_M,
  output logic [NUM_M-1:0]                      ARREADY_M,
  output logic [NUM_M*`AXI_ID_BITS-1:0]         RID_M,
  output logic [NUM_M*`AXI_DATA_BITS-1:0]       RDATA_M,
  output logic [NUM_M*`AXI_RESP_BITS-1:0]       RRESP_M,
  output logic [NUM_M-1:0]                      RLAST_M,
  output logic [NUM_M-1:0]                      RVALID_M,
  input  logic [NUM_M-1:0]                      RREADY_M,
  output logic [`AXI_IDS_BITS-1:0]              ARID_S,
  output logic [`AXI_ADDR_BITS-1:0]             ARADDR_S,
  output logic [`AXI_LEN_BITS-1:0]              ARLEN_S,
  output logic [`AXI_SIZE_BITS-1:0]             ARSIZE_S,
  output logic [`AXI_BURST_BITS-1:0]            ARBURST_S,
  output logic                                  ARVALID_S,
  input  logic                                  ARREADY_S,
  input  logic [`AXI_IDS_BITS-1:0]              RID_S,
  input  logic [`AXI_DATA_BITS-1:0]             RDATA_S,
  input  logic [`AXI_RESP_BITS-1:0]             RRESP_S,
  input  logic                                  RLAST_S,
  input  logic                                  RVALID_S,
  output logic                                  RREADY_S,
  output logic [MIDX_BITS-1:0]                  grant_idx,
  output logic                                  busy
);

  localparam int IDW  = `AXI_ID_BITS;
  localparam int IDSW = `AXI_IDS_BITS;
  localparam int AW   = `AXI_ADDR_BITS;
  localparam int LW   = `AXI_LEN_BITS;
  localparam int SW   = `AXI_SIZE_BITS;
  localparam int BW   = `AXI_BURST_BITS;

  arb_state_e state_q, state_d;
  logic [MIDX_BITS-1:0] grant_q;
  logic [IDW-1:0]       id_q;
  logic [AW-1:0]        addr_q;
  logic [LW-1:0]        len_q;
  logic [SW-1:0]        size_q;
  logic [BW-1:0]        burst_q;

  logic                 pick_any;
  logic [MIDX_BITS-1:0] pick_idx;
  logic [IDW-1:0]       win_id;
  logic [AW-1:0]        win_addr;
  logic [LW-1:0]        win_len;
  logic [SW-1:0]        win_size;
  logic [BW-1:0]        win_burst;
  logic [IDSW-IDW-1:0]  grant_ext;

`ifdef ARB_RR_EN
  logic [MIDX_BITS-1:0] ptr_q;
`endif

  arb_pick #(
    .NUM_M     (NUM_M),
    .MIDX_BITS (MIDX_BITS)
  ) u_pick (
`ifdef ARB_RR_EN
    .ptr    (ptr_q),
`endif
    .req    (ARVALID_M),
    .any    (pick_any),
    .winner (pick_idx)
  );

  always_comb begin
    win_id    = '0;
    win_addr  = '0;
    win_len   = '0;
    win_size  = '0;
    win_burst = '0;
    for (int m = 0; m < NUM_M; m++) begin
      if (pick_idx == MIDX_BITS'(m)) begin
        win_id    = ARID_M[m*IDW +: IDW];
        win_addr  = ARADDR_M[m*AW +: AW];
        win_len   = ARLEN_M[m*LW +: LW];
        win_size  = ARSIZE_M[m*SW +: SW];
        win_burst = ARBURST_M[m*BW +: BW];
      end
    end
  end

  // Channel steering toward the owner; non-owners see idle handshakes.
  always_comb begin
    ARREADY_M = '0;
    RVALID_M  = '0;
    RREADY_S  = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      if (grant_q == MIDX_BITS'(m)) begin
        if (state_q == S_ADDR) ARREADY_M[m] = ARREADY_S;
        if (state_q == S_DATA) begin
          RVALID_M[m] = RVALID_S;
          RREADY_S    = RREADY_M[m];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_any) state_d = S_ADDR;
      S_ADDR:  if (ARREADY_S) state_d = S_DATA;
      S_DATA:  if (RVALID_S && RREADY_S && RLAST_S) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
`ifdef ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && pick_any) begin
        grant_q <= pick_idx;
        id_q    <= win_id;
        addr_q  <= win_addr;
        len_q   <= win_len;
        size_q  <= win_size;
        burst_q <= win_burst;
`ifdef ARB_RR_EN
        if (int'(pick_idx) == NUM_M - 1) ptr_q <= '0;
        else                             ptr_q <= pick_idx + 1'b1;
`endif
      end
    end
  end

  assign grant_ext = (IDSW-IDW)'(grant_q);
  assign ARVALID_S = (state_q == S_ADDR);
  assign ARID_S    = {grant_ext, id_q};
  assign ARADDR_S  = addr_q;
  assign ARLEN_S   = len_q;
  assign ARSIZE_S  = size_q;
  assign ARBURST_S = burst_q;

  assign RID_M     = {NUM_M{RID_S[IDW-1:0]}};
  assign RDATA_M   = {NUM_M{RDATA_S}};
  assign RRESP_M   = {NUM_M{RRESP_S}};
  assign RLAST_M   = {NUM_M{RLAST_S}};

  assign grant_idx = grant_q;
  assign busy      = (state_q != S_IDLE);

  // Slaves echo ARID, so the routing tag on returning beats must name the current owner.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_DATA && RVALID_S) begin
      assert (RID_S[IDSW-1:IDW] == grant_ext);
    end
  end

endmodule
